trans_sender: RTL and testbench
===============================

# trans_sender

Transaction issuer for the memory checker. It sits between the address generator and the memory-side Avalon-MM-style master port. On a test start it requests addresses one at a time through the address generator's `next_addr_en` handshake. For each address it issues write and/or read commands with a deterministic data pattern, holding each command until the memory accepts it. It reports busy while running and pulses done when the programmed transaction count is exhausted.

## Interface
- `ADDR_W`, 12: address width; must equal the address generator's width; ≥ 8.
- `DATA_W`, 32: write-data width; multiple of 8.
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `start_test_i`  in  1  one-cycle test start strobe; same strobe the address generator sees.
- `test_param_i`  in  [2:0][31:0]  CSR test parameters:
  - [0][15:0] transaction count N;
  - [0][31:24] pattern byte P;
  - [1][15:14] op mode: 00 write-only, 01 read-only, 10 write-then-read, 11 treated as 00;
  - all other bits ignored.
- `next_addr_i`  in  ADDR_W  current address from the address generator; changes only on the edge after `next_addr_en_o`=1.
- `next_addr_en_o`  out  1  combinational; advance the address generator.
- `mem_address_o`  out  ADDR_W  command address, registered.
- `mem_write_o`  out  1  write command, registered.
- `mem_read_o`  out  1  read command, registered.
- `mem_writedata_o`  out  DATA_W  write data, registered.
- `mem_waitrequest_i`  in  1  memory stall; a command is accepted on a cycle where it is asserted and `mem_waitrequest_i`=0.
- `busy_o`  out  1  test in progress.
- `done_o`  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, LOAD, WR, RD, DONE.
- **IDLE**
  - On `start_test_i`, latch N, P and op mode into internal registers.
  - N=0: go to DONE. Otherwise go to LOAD with remaining count `rem_r`=N.
  - Param changes after start have no effect until the next start.
- **LOAD** (one cycle)
  - Latch `addr_r` <= `next_addr_i`.
  - Next state: RD if op mode is 01, else WR.
- **WR**
  - `mem_write_o`=1, `mem_address_o`=`addr_r`.
  - `mem_writedata_o` = P ^ `addr_r[7:0]`, replicated DATA_W/8 times.
  - On accept: op mode 10 goes to RD with the same `addr_r`. Otherwise this is the address's final command.
- **RD**
  - `mem_read_o`=1, `mem_address_o`=`addr_r`.
  - On accept this is always the address's final command.
- **Final-command accept**
  - `next_addr_en_o`=1 for that cycle, and `rem_r` decrements.
  - If `rem_r` was 1, go to DONE; else go to LOAD.
  - A write-then-read pair counts as one transaction.
- **DONE** (one cycle): `done_o`=1, `busy_o`=0, then return to IDLE.
- `busy_o`=1 in LOAD, WR and RD only.
- `start_test_i` outside IDLE is ignored; it does not restart and does not reload.
- `next_addr_en_o` = (state is WR with op mode ≠ 10, or state is RD) and `mem_write_o|mem_read_o` and !`mem_waitrequest_i`. It is never asserted in IDLE, LOAD or DONE.
- `mem_write_o` and `mem_read_o` are never both 1.
- Command signals hold stable while `mem_waitrequest_i`=1.
- `rem_r` is 16 bits; N=65535 is legal; there is no wrap.

## Timing
- **Reset:** `rst_i`=1 at any edge, including mid-command, forces:
  - state IDLE;
  - `mem_write_o`, `mem_read_o`, `busy_o`, `done_o`, `next_addr_en_o` = 0;
  - `mem_address_o` = 0, `mem_writedata_o` = 0, `rem_r` = 0.
  - A command in flight is abandoned, not completed.
- **Start:** `start_test_i` at edge T0 → LOAD in cycle T0+1, with `busy_o` rising there. The address generator has loaded its first address by then.
- **First command:** `mem_write_o`/`mem_read_o` asserted in cycle T0+2.
- **Throughput with zero wait states:**
  - single-op modes: 2 cycles per transaction (LOAD + command);
  - write-then-read: 3 cycles per transaction.
- **Address hand-off:** `next_addr_en_o` on the accept cycle; the generator updates on that edge; the following LOAD samples the new address.
- **Completion:** last accept at cycle A → DONE in A+1 (`done_o`=1, `busy_o`=0), IDLE in A+2.
- **Zero count:** N=0 gives `done_o` in T0+1; no commands and no `next_addr_en_o`.

## Test plan
- **Write-only, no stall.** N=3, P=0xA5, addresses 0x010, 0x011, 0x012.
  - Expect: writes at cycles T0+2, +4, +6 with data 0xB5B5B5B5, 0xB4B4B4B4, 0xB7B7B7B7.
  - Expect: 3 `next_addr_en_o` pulses; `done_o` at T0+7.
- **Write-then-read.** N=2, fixed address 0x020, P=0x00.
  - Expect: order is W, R, W, R, all at 0x020.
  - Expect: `next_addr_en_o` only on the read accepts; write data 0x20202020.
- **Read-only with waitrequest.** N=1; hold `mem_waitrequest_i`=1 for 4 cycles.
  - Expect: `mem_read_o` and address stable for 5 cycles.
  - Expect: single `next_addr_en_o` in the 5th cycle; `done_o` the next cycle.
- **Zero count.** N=0.
  - Expect: `done_o` at T0+1; no `mem_write_o`, `mem_read_o` or `next_addr_en_o`; `busy_o` stays 0.
- **Start while busy.** Second `start_test_i` mid-test with a different N.
  - Expect: ignored; the original N transactions complete.
- **Mid-command reset.** Assert `rst_i` during a stalled write.
  - Expect: all outputs 0 the next cycle.
  - Expect: a subsequent start runs normally from LOAD.

Source files
------------

// File: rtl/trans_sender.sv
// trans_sender: walks generator addresses and issues write/read commands with a pattern, holding each until accepted.
module trans_sender #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_test_i,
  input  logic [2:0][31:0]       test_param_i,
  input  logic [ADDR_W-1:0]      next_addr_i,
  output logic                   next_addr_en_o,
  output logic [ADDR_W-1:0]      mem_address_o,
  output logic                   mem_write_o,
  output logic                   mem_read_o,
  output logic [DATA_W-1:0]      mem_writedata_o,
  input  logic                   mem_waitrequest_i,
  output logic                   busy_o,
  output logic                   done_o
);
  typedef enum logic [2:0] {IDLE, LOAD, WR, RD, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0] pat_q, pat_d;
  logic [1:0] mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic wr_q, rd_q, accept, last;
  logic unused_bits;
  assign unused_bits = ^{test_param_i[2], test_param_i[1][31:16], test_param_i[1][13:0], test_param_i[0][23:16]};
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    pat_d = pat_q;
    mode_d = mode_q;
    addr_d = addr_q;
    accept = (wr_q | rd_q) & ~mem_waitrequest_i;
    last = accept & (state_q == RD | (state_q == WR & mode_q != 2'b10));
    case (state_q)
      IDLE: if (start_test_i) begin
        rem_d = test_param_i[0][15:0];
        pat_d = test_param_i[0][31:24];
        mode_d = (&test_param_i[1][15:14]) ? 2'b00 : test_param_i[1][15:14];
        state_d = (test_param_i[0][15:0] == 16'd0) ? DONE : LOAD;
      end
      LOAD: begin
        addr_d = next_addr_i;
        state_d = (mode_q == 2'b01) ? RD : WR;
      end
      WR: if (accept && mode_q == 2'b10) state_d = RD;
      DONE: state_d = IDLE;
      default: ;
    endcase
    if (last) begin
      rem_d = rem_q - 16'd1;
      state_d = (rem_q == 16'd1) ? DONE : LOAD;
    end
    wdata_d = (state_d == WR) ? {(DATA_W/8){pat_q ^ addr_d[7:0]}} : wdata_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q <= '0;
      pat_q <= '0;
      mode_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      pat_q <= pat_d;
      mode_q <= mode_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wr_q <= state_d == WR;
      rd_q <= state_d == RD;
    end
  end
  assign next_addr_en_o = last;
  assign mem_address_o = addr_q;
  assign mem_write_o = wr_q;
  assign mem_read_o = rd_q;
  assign mem_writedata_o = wdata_q;
  assign busy_o = state_q == LOAD || state_q == WR || state_q == RD;
  assign done_o = state_q == DONE;
endmodule

// File: tb/tb_trans_sender.sv
// tb_trans_sender: randomized and directed runs checked against a command-list model of each test.
module tb_trans_sender;
  logic clk = 0;
  always #5 clk = ~clk;
  logic rst_i = 1, start_test_i = 0, mem_waitrequest_i = 0;
  logic [2:0][31:0] test_param_i = '0;
  logic [11:0] gen_addr = 0, gen_base = 0, gen_step = 0;
  logic gen_load = 0;
  logic next_addr_en_o, mem_write_o, mem_read_o, busy_o, done_o;
  logic [11:0] mem_address_o;
  logic [31:0] mem_writedata_o;
  trans_sender dut (
    .clk_i(clk), .rst_i(rst_i), .start_test_i(start_test_i), .test_param_i(test_param_i),
    .next_addr_i(gen_addr), .next_addr_en_o(next_addr_en_o), .mem_address_o(mem_address_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_writedata_o(mem_writedata_o),
    .mem_waitrequest_i(mem_waitrequest_i), .busy_o(busy_o), .done_o(done_o)
  );
  always @(posedge clk) gen_addr <= gen_load ? gen_base : next_addr_en_o ? gen_addr + gen_step : gen_addr;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  typedef struct packed {logic wr; logic [11:0] a; logic [31:0] d; logic fin;} cmd_t;
  cmd_t expq[$];
  cmd_t e;
  bit active = 0, done_seen = 0, stall_prev = 0, prev_w = 0, prev_r = 0;
  logic [11:0] prev_a = 0;
  logic [31:0] prev_d = 0;
  int t0 = 0, n_cur = 0, done_cyc = 0, last_acc = 0, en_cnt = 0;
  always @(negedge clk) begin
    if (rst_i) stall_prev = 0;
    else if (active) begin
      if (stall_prev) begin
        check("hold_cmd", {mem_write_o, mem_read_o}, {prev_w, prev_r});
        check("hold_addr", mem_address_o, prev_a);
        if (prev_w) check("hold_data", mem_writedata_o, prev_d);
      end
      if (mem_write_o | mem_read_o) check("excl", mem_write_o & mem_read_o, 0);
      if ((mem_write_o | mem_read_o) && !mem_waitrequest_i) begin
        if (expq.size() == 0) check("extra_cmd", mem_write_o | mem_read_o, 0);
        else begin
          e = expq.pop_front();
          check("kind", mem_write_o, e.wr);
          check("addr", mem_address_o, e.a);
          if (e.wr) check("wdata", mem_writedata_o, e.d);
          check("addr_en", next_addr_en_o, e.fin);
        end
        last_acc = cyc;
      end else if (next_addr_en_o) check("addr_en_idle", next_addr_en_o, 0);
      if (next_addr_en_o) en_cnt++;
      if (done_o) begin
        check("done_once", done_seen, 0);
        done_seen = 1;
        done_cyc = cyc;
      end
      check("busy", busy_o, n_cur > 0 && cyc > t0 && !done_seen);
      stall_prev = (mem_write_o | mem_read_o) & mem_waitrequest_i;
      prev_w = mem_write_o;
      prev_r = mem_read_o;
      prev_a = mem_address_o;
      prev_d = mem_writedata_o;
    end
  end
  task automatic run(input int n, input logic [7:0] p, input logic [1:0] m, input logic [11:0] base,
                     input logic [11:0] step, input int wm, input bit restart);
    logic [11:0] a;
    int exp_done, k;
    expq.delete();
    for (int i = 0; i < n; i++) begin
      a = base + 12'(i) * step;
      if (m != 2'd1) expq.push_back(cmd_t'{1'b1, a, {4{p ^ a[7:0]}}, m != 2'd2});
      if (m == 2'd1 || m == 2'd2) expq.push_back(cmd_t'{1'b0, a, 32'h0, 1'b1});
    end
    @(posedge clk) #1;
    test_param_i[0] = {p, 8'($urandom), 16'(n)};
    test_param_i[1] = {16'($urandom), m, 14'($urandom)};
    test_param_i[2] = $urandom;
    start_test_i = 1;
    gen_load = 1;
    gen_base = base;
    gen_step = step;
    mem_waitrequest_i = 0;
    t0 = cyc;
    n_cur = n;
    done_seen = 0;
    en_cnt = 0;
    last_acc = 0;
    stall_prev = 0;
    active = 1;
    k = 0;
    while (!done_seen && k < 500) begin
      @(posedge clk) #1;
      k++;
      start_test_i = 0;
      gen_load = 0;
      if (k == 1) test_param_i = {$urandom, $urandom, $urandom};
      if (restart && k == 3) begin
        start_test_i = 1;
        test_param_i[0][15:0] = 16'd7;
      end
      mem_waitrequest_i = wm == 1 ? ($urandom_range(0, 2) == 0) : wm == 2 ? (cyc >= t0 + 2 && cyc <= t0 + 5) : 1'b0;
    end
    check("timeout", done_seen, 1);
    exp_done = n == 0 ? t0 + 1 : wm == 0 ? t0 + 1 + n * (m == 2'd2 ? 3 : 2) : last_acc + 1;
    check("done_cyc", done_cyc, exp_done);
    if (wm == 2) check("stall_done", done_cyc, t0 + 7);
    check("left", expq.size(), 0);
    check("en_cnt", en_cnt, n);
    mem_waitrequest_i = 0;
    start_test_i = 0;
    repeat (2) @(posedge clk);
    #1 active = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr", mem_write_o, 0);
    check("rst_rd", mem_read_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_en", next_addr_en_o, 0);
    check("rst_addr", mem_address_o, 0);
    check("rst_data", mem_writedata_o, 0);
    rst_i = 0;
    run(3, 8'hA5, 2'd0, 12'h010, 12'd1, 0, 0);
    run(2, 8'h00, 2'd2, 12'h020, 12'd0, 0, 0);
    run(1, 8'h3C, 2'd1, 12'h3FF, 12'd1, 2, 0);
    run(0, 8'h77, 2'd2, 12'h040, 12'd1, 0, 0);
    run(3, 8'h11, 2'd0, 12'h050, 12'd1, 0, 1);
    run(4, 8'h5A, 2'd2, 12'h0FE, 12'd1, 0, 0);
    run(3, 8'hC3, 2'd3, 12'h200, 12'd2, 0, 0);
    gen_base = 12'h100;
    gen_step = 12'd1;
    @(posedge clk) #1;
    test_param_i[0] = {8'h3C, 8'h00, 16'd2};
    test_param_i[1] = '0;
    start_test_i = 1;
    gen_load = 1;
    mem_waitrequest_i = 1;
    @(posedge clk) #1;
    start_test_i = 0;
    gen_load = 0;
    repeat (3) @(posedge clk);
    #1 check("stall_wr", mem_write_o, 1);
    rst_i = 1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_wr", mem_write_o, 0);
    check("mid_rst_rd", mem_read_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_done", done_o, 0);
    check("mid_rst_en", next_addr_en_o, 0);
    check("mid_rst_addr", mem_address_o, 0);
    check("mid_rst_data", mem_writedata_o, 0);
    rst_i = 0;
    mem_waitrequest_i = 0;
    run(2, 8'h3C, 2'd0, 12'h100, 12'd1, 0, 0);
    for (int r = 0; r < 20; r++)
      run($urandom_range(1, 5), 8'($urandom), 2'($urandom), 12'($urandom), 12'($urandom_range(0, 3)), 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
